// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared types and widths for the Wishbone round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int WB_CNT_W = 16;

    // IDLE doubles as the re-arbitration slot between owners
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_rr_pick
//  Description : Combinational round-robin picker. Returns the first
//                requester strictly after i_last_gnt in circular order,
//                using a double-width masked lowest-set-bit search.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last_gnt,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic                   o_valid
);

    localparam int c_DW = 2 * NUM_MASTERS;

    logic [c_DW-1:0] w_mask;
    logic [c_DW-1:0] w_masked;
    logic [c_DW-1:0] w_first;

    // Mask off everything up to and including the last winner in the lower
    // copy; the upper copy supplies the wrap-around candidates.
    always_comb begin
        w_mask   = {c_DW{1'b1}} << ({1'b0, i_last_gnt} + 1'b1);
        w_masked = {i_req, i_req} & w_mask;
        w_first  = w_masked & (~w_masked + {{(c_DW-1){1'b0}}, 1'b1});
        o_gnt    = w_first[NUM_MASTERS-1:0] | w_first[c_DW-1:NUM_MASTERS];
        o_valid  = |i_req;
    end

endmodule : wb_arb_rr_pick
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Round-robin Wishbone arbiter sharing one slave port between
//                NUM_MASTERS masters. A master owns the slave for the whole of
//                its cyc; one idle cycle separates consecutive owners.
//                Optional watchdog compiled in with `WB_ARB_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]          wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]          wbm_stb_i,
    input  logic [NUM_MASTERS-1:0]          wbm_we_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] wbm_sel_i,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] wbm_adr_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] wbm_dat_i,
    output logic [WB_DAT_W-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]          wbm_ack_o,
    output logic [NUM_MASTERS-1:0]          wbm_err_o,
    output logic                            wbs_cyc_o,
    output logic                            wbs_stb_o,
    output logic                            wbs_we_o,
    output logic [WB_SEL_W-1:0]             wbs_sel_o,
    output logic [WB_ADR_W-1:0]             wbs_adr_o,
    output logic [WB_DAT_W-1:0]             wbs_dat_o,
    input  logic [WB_DAT_W-1:0]             wbs_dat_i,
    input  logic                            wbs_ack_i,
    input  logic                            wbs_err_i,
    output logic [NUM_MASTERS-1:0]          gnt_o
);

    localparam int                 c_IDX_W    = $clog2(NUM_MASTERS);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_arbiter: NUM_MASTERS must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT must be 1..65535");
    end

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [NUM_MASTERS-1:0] w_gnt_nxt;
    logic [c_IDX_W-1:0]     r_last_gnt;
    logic [c_IDX_W-1:0]     w_last_nxt;
    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic                   w_pick_valid;
    logic [c_IDX_W-1:0]     w_pick_idx;
    logic                   w_own_cyc;
    logic                   w_own_stb;
    logic                   w_timeout;

    wb_arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_pick (
        .i_req      (wbm_cyc_i),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_pick_gnt),
        .o_valid    (w_pick_valid)
    );

    // Encode the one-hot pick so last_gnt can be kept as an index
    always_comb begin
        w_pick_idx = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (w_pick_gnt[m]) begin
                w_pick_idx = c_IDX_W'(m);
            end
        end
    end

    // AND-OR mux of the granted master; an all-zero grant yields all-zero
    // slave outputs, which is exactly the idle/reset appearance
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_own_cyc = w_own_cyc | (r_gnt[m] & wbm_cyc_i[m]);
            w_own_stb = w_own_stb | (r_gnt[m] & wbm_stb_i[m]);
            wbs_we_o  = wbs_we_o  | (r_gnt[m] & wbm_we_i[m]);
            wbs_sel_o = wbs_sel_o | ({WB_SEL_W{r_gnt[m]}} & wbm_sel_i[WB_SEL_W*m +: WB_SEL_W]);
            wbs_adr_o = wbs_adr_o | ({WB_ADR_W{r_gnt[m]}} & wbm_adr_i[WB_ADR_W*m +: WB_ADR_W]);
            wbs_dat_o = wbs_dat_o | ({WB_DAT_W{r_gnt[m]}} & wbm_dat_i[WB_DAT_W*m +: WB_DAT_W]);
        end
    end

    assign wbs_cyc_o = w_own_cyc;
    // A watchdog expiry withdraws the strobe in the cycle the error is issued
    assign wbs_stb_o = w_own_stb & ~w_timeout;

    // Responses go only to the owner; an abandoned transfer's late ack finds
    // no grant and is dropped
    assign wbm_ack_o = r_gnt & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = r_gnt & {NUM_MASTERS{wbs_err_i | w_timeout}};
    assign wbm_dat_o = wbs_dat_i;
    assign gnt_o     = r_gnt;

    // Next-state: grab a winner from IDLE, release when the owner drops cyc
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_OWNED;
                    w_gnt_nxt   = w_pick_gnt;
                    w_last_nxt  = w_pick_idx;
                end
            end
            ST_OWNED: begin
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State, grant and rotation pointer registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_last_gnt <= c_LAST_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last_gnt <= w_last_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [WB_CNT_W-1:0] c_TIMEOUT = WB_CNT_W'(TIMEOUT);

    logic [WB_CNT_W-1:0] r_wd_cnt;

    // A real slave response in the expiry cycle takes precedence
    assign w_timeout = (r_state == ST_OWNED) && (r_wd_cnt == c_TIMEOUT)
                     && !wbs_ack_i && !wbs_err_i;

    // Count strobed, unanswered owner cycles
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wd_cnt <= '0;
        end else if ((r_state != ST_OWNED) || !w_own_cyc || wbs_ack_i
                     || wbs_err_i || w_timeout) begin
            r_wd_cnt <= '0;
        end else if (wbs_stb_o) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: ownership/rotation model
//                compared every cycle plus directed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int N    = 4;
    localparam int C_TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [4*N-1:0]  m_sel = '0;
    logic [32*N-1:0] m_adr = '0, m_dat = '0;
    logic [31:0]     wbm_dat_o;
    logic [N-1:0]    wbm_ack_o, wbm_err_o, gnt_o;
    logic            s_cyc, s_stb, s_we;
    logic [3:0]      s_sel;
    logic [31:0]     s_adr, s_dat, s_rdat;
    logic            s_ack, s_err;
    logic            ack_auto = 1'b0, ack_force = 1'b0, err_force = 1'b0;

    assign s_ack  = (ack_auto & s_cyc) | ack_force;
    assign s_err  = err_force;
    assign s_rdat = s_adr ^ 32'h5A5A_0000;

    wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(C_TO)) dut (
        .wb_clk_i (clk),      .wb_rst_n_i (rst_n),
        .wbm_cyc_i(m_cyc),    .wbm_stb_i (m_stb),   .wbm_we_i (m_we),
        .wbm_sel_i(m_sel),    .wbm_adr_i (m_adr),   .wbm_dat_i(m_dat),
        .wbm_dat_o(wbm_dat_o),.wbm_ack_o (wbm_ack_o),.wbm_err_o(wbm_err_o),
        .wbs_cyc_o(s_cyc),    .wbs_stb_o (s_stb),   .wbs_we_o (s_we),
        .wbs_sel_o(s_sel),    .wbs_adr_o (s_adr),   .wbs_dat_o(s_dat),
        .wbs_dat_i(s_rdat),   .wbs_ack_i (s_ack),   .wbs_err_i(s_err),
        .gnt_o    (gnt_o)
    );

    int n_chk = 0, n_pass = 0, ncnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncnt);
    endtask

    // ---------------- behavioural model: owner index, rotation pointer -----
    int owner = -1, last = N - 1, wd = 0;
    int nxt_owner = -1, nxt_last = N - 1, nxt_wd = 0;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {int idx; int cyc; logic [31:0] adr; logic [31:0] dat; logic [N-1:0] gnt; logic [N-1:0] ack;} glog_t;
    glog_t        glog[$];
    logic [N-1:0] prev_gnt = '0;
    int           ack_cnt[N];
    logic [N-1:0] err_h[0:2047];
    logic [N-1:0] ack_h[0:2047];
    logic         stb_h[0:2047];

    always @(negedge clk) begin : p_cmp
        logic [N-1:0] e_gnt, e_ack, e_err;
        logic [6:0]   e_ctl;
        logic [31:0]  e_adr, e_dat;
        bit           fire;
        int           gi;
        ncnt++;
        fire  = TO_EN && owner >= 0 && wd == C_TO && !s_ack && !s_err;
        e_gnt = '0; e_ack = '0; e_err = '0; e_ctl = '0; e_adr = '0; e_dat = '0;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            e_ctl = {m_cyc[owner], m_stb[owner] & ~fire, m_we[owner], m_sel[4*owner +: 4]};
            e_adr = m_adr[32*owner +: 32];
            e_dat = m_dat[32*owner +: 32];
            if (s_ack)         e_ack[owner] = 1'b1;
            if (s_err || fire) e_err[owner] = 1'b1;
        end
        check("gnt",       64'(gnt_o), 64'(e_gnt));
        check("slave_ctl", 64'({s_cyc, s_stb, s_we, s_sel}), 64'(e_ctl));
        check("slave_adr", 64'(s_adr), 64'(e_adr));
        check("slave_dat", 64'(s_dat), 64'(e_dat));
        check("ack",       64'(wbm_ack_o), 64'(e_ack));
        check("err",       64'(wbm_err_o), 64'(e_err));
        check("rdata",     64'(wbm_dat_o), 64'(s_rdat));
        if (ncnt < 2048) begin
            err_h[ncnt] = wbm_err_o; ack_h[ncnt] = wbm_ack_o; stb_h[ncnt] = s_stb;
        end
        for (int m = 0; m < N; m++) ack_cnt[m] += int'(wbm_ack_o[m]);
        if (gnt_o != '0 && prev_gnt == '0) begin
            gi = -1;
            for (int m = 0; m < N; m++) if (gnt_o[m]) gi = m;
            glog.push_back('{gi, ncnt, s_adr, s_dat, gnt_o, wbm_ack_o});
        end
        prev_gnt = gnt_o;
        // next model state from the rules: rotate from IDLE, hold while cyc
        if (!rst_n) begin
            nxt_owner = -1; nxt_last = N - 1; nxt_wd = 0;
        end else begin
            nxt_owner = owner; nxt_last = last; nxt_wd = wd;
            if (owner < 0) begin
                nxt_wd = 0;
                for (int k = 1; k <= N; k++) begin
                    if (nxt_owner < 0 && m_cyc[(last + k) % N]) begin
                        nxt_owner = (last + k) % N;
                        nxt_last  = (last + k) % N;
                    end
                end
            end else if (!m_cyc[owner]) begin
                nxt_owner = -1; nxt_wd = 0;
            end else if (s_ack || s_err || fire) begin
                nxt_wd = 0;
            end else if (m_stb[owner]) begin
                nxt_wd = wd + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= -1; last <= N - 1; wd <= 0;
        end else begin
            owner <= nxt_owner; last <= nxt_last; wd <= nxt_wd;
        end
    end

    // ---------------- master drivers ---------------------------------------
    int beats[N];
    int drop_at[N];

    function automatic bit busy();
        busy = 1'b0;
        for (int m = 0; m < N; m++) if (beats[m] > 0) busy = 1'b1;
    endfunction

    function automatic int gl_idx(input int i);
        gl_idx = (i < glog.size()) ? glog[i].idx : -1;
    endfunction

    function automatic int gl_cyc(input int i);
        gl_cyc = (i < glog.size()) ? glog[i].cyc : -1;
    endfunction

    task automatic tick();
        logic [N-1:0] a;
        @(negedge clk);
        a = wbm_ack_o;
        @(posedge clk);
        #1;
        for (int m = 0; m < N; m++) begin
            if (a[m] && beats[m] > 0) begin
                beats[m]--;
                if (beats[m] == 0) begin
                    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; drop_at[m] = ncnt + 1;
                end
            end
        end
    endtask

    task automatic start(input int m, input int nb, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        beats[m] = nb;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
        m_sel[4*m +: 4]   = sel;
        m_adr[32*m +: 32] = adr;
        m_dat[32*m +: 32] = dat;
    endtask

    task automatic run_done(input string name, input int budget);
        int k = 0;
        while (busy() && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(k < budget), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        ack_auto = 1'b0; ack_force = 1'b0; err_force = 1'b0;
        for (int m = 0; m < N; m++) begin beats[m] = 0; drop_at[m] = 0; end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        glog.delete();
        for (int m = 0; m < N; m++) ack_cnt[m] = 0;
    endtask

    initial begin : p_stim
        int r, g;

        // T1: reset state, then one master-2 write
        do_reset();
        @(negedge clk);
        check("rst_gnt",   64'(gnt_o), 64'd0);
        check("rst_slave", 64'({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat}), 64'd0);
        check("rst_resp",  64'({wbm_ack_o, wbm_err_o}), 64'd0);
        @(posedge clk); #1;
        ack_auto = 1'b1;
        r = ncnt + 1;
        start(2, 1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        run_done("t1_done", 20);
        check("t1_n_grants", 64'(glog.size()), 64'd1);
        check("t1_idx",      64'(gl_idx(0)), 64'd2);
        check("t1_latency",  64'(gl_cyc(0)), 64'(r + 1));
        if (glog.size() > 0) begin
            check("t1_gnt", 64'(glog[0].gnt), 64'b0100);
            check("t1_ack", 64'(glog[0].ack), 64'b0100);
            check("t1_adr", 64'(glog[0].adr), 64'h10);
            check("t1_dat", 64'(glog[0].dat), 64'hDEAD_BEEF);
        end
        check("t1_acks_m2",    64'(ack_cnt[2]), 64'd1);
        check("t1_acks_other", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[3]), 64'd0);

        // T2: 0, 1, 3 request together -> 0, 1, 3, three cycles apart
        do_reset();
        ack_auto = 1'b1;
        r = ncnt + 1;
        start(0, 1, 1'b0, 32'h100, 32'h0, 4'hF);
        start(1, 1, 1'b0, 32'h104, 32'h0, 4'hF);
        start(3, 1, 1'b0, 32'h10C, 32'h0, 4'hF);
        run_done("t2_done", 40);
        check("t2_n_grants", 64'(glog.size()), 64'd3);
        check("t2_first",  64'(gl_idx(0)), 64'd0);
        check("t2_second", 64'(gl_idx(1)), 64'd1);
        check("t2_third",  64'(gl_idx(2)), 64'd3);
        check("t2_cyc0", 64'(gl_cyc(0)), 64'(r + 1));
        check("t2_cyc1", 64'(gl_cyc(1)), 64'(r + 4));
        check("t2_cyc2", 64'(gl_cyc(2)), 64'(r + 7));
        check("t2_acks", 64'({ack_cnt[3][7:0], ack_cnt[2][7:0], ack_cnt[1][7:0], ack_cnt[0][7:0]}),
              64'h01_00_01_01);

        // T3: master 1 burst of 4 holds off master 0
        do_reset();
        ack_auto = 1'b1;
        r = ncnt + 1;
        start(1, 4, 1'b1, 32'h200, 32'h1111_2222, 4'h3);
        tick();
        start(0, 1, 1'b0, 32'h300, 32'h0, 4'hF);
        run_done("t3_done", 40);
        check("t3_n_grants", 64'(glog.size()), 64'd2);
        check("t3_first",   64'(gl_idx(0)), 64'd1);
        check("t3_cyc0",    64'(gl_cyc(0)), 64'(r + 1));
        check("t3_acks_m1", 64'(ack_cnt[1]), 64'd4);
        check("t3_drop",    64'(drop_at[1]), 64'(r + 5));
        check("t3_second",  64'(gl_idx(1)), 64'd0);
        check("t3_handover",64'(gl_cyc(1)), 64'(drop_at[1] + 2));

        // T4: slave never answers master 0
        do_reset();
        r = ncnt + 1;
        start(0, 1, 1'b0, 32'h400, 32'h0, 4'hF);
        g = r + 1;
        repeat (12) tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0; beats[0] = 0;
        repeat (2) tick();
        check("t4_n_grants", 64'(glog.size()), 64'd1);
        check("t4_err_pre",  64'(err_h[g+7]), 64'd0);
        check("t4_stb_pre",  64'(stb_h[g+7]), 64'd1);
`ifdef WB_ARB_TIMEOUT_EN
        check("t4_err_fire", 64'(err_h[g+8]), 64'b0001);
        check("t4_stb_fire", 64'(stb_h[g+8]), 64'd0);
        check("t4_err_post", 64'(err_h[g+9]), 64'd0);
        check("t4_stb_post", 64'(stb_h[g+9]), 64'd1);
`else
        check("t4_err_none", 64'(err_h[g+8]), 64'd0);
        check("t4_stb_held", 64'(stb_h[g+8]), 64'd1);
`endif

        // T5: slave answers exactly when the watchdog would expire
        do_reset();
        r = ncnt + 1;
        start(0, 1, 1'b0, 32'h500, 32'h0, 4'hF);
        g = r + 1;
        repeat (9) tick();
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        run_done("t5_done", 10);
        check("t5_ack", 64'(ack_h[g+8]), 64'b0001);
        check("t5_err", 64'(err_h[g+8]), 64'd0);
        check("t5_stb", 64'(stb_h[g+8]), 64'd1);

        // T6: asynchronous reset during a master-2 transfer
        do_reset();
        start(2, 1, 1'b1, 32'h600, 32'hCAFE_F00D, 4'hF);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        ack_force = 1'b1;
        #1;
        check("t6_rst_gnt",   64'(gnt_o), 64'd0);
        check("t6_rst_slave", 64'({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat}), 64'd0);
        check("t6_rst_resp",  64'({wbm_ack_o, wbm_err_o}), 64'd0);
        ack_force = 1'b0;
        @(posedge clk); #1;
        start(0, 1, 1'b0, 32'h700, 32'h0, 4'hF);
        glog.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        r = ncnt + 1;
        ack_auto = 1'b1;
        run_done("t6_done", 30);
        check("t6_n_grants", 64'(glog.size()), 64'd2);
        check("t6_first",    64'(gl_idx(0)), 64'd0);
        check("t6_cyc0",     64'(gl_cyc(0)), 64'(r + 1));
        check("t6_second",   64'(gl_idx(1)), 64'd2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global guard so a stuck run still reports
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule : tb_wb_arbiter
`default_nettype wire
